// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage wrapped around an external 4x4 combinational multiplier.
// Optional build macro SATURATE_EN: clamp the accumulator at 2^ACC_W-1 instead of wrapping.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_ACCUM | accepting operand pairs and summing products
// ST_DONE  | holding the finished sum for the downstream side
module mac_accumulator #(
    parameter int COUNT = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;
    localparam logic [7:0] COUNT_C  = 8'(COUNT);

    logic [0:0]       state_q,    state_d;
    logic [7:0]       acc_cnt_q,  acc_cnt_d;
    logic [7:0]       add_cnt_q,  add_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic [3:0]       mul_a_q,    mul_a_d;
    logic [3:0]       mul_b_q,    mul_b_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic             ovf_q,      ovf_d;

    logic             accept;
    logic             release_out;
    logic [ACC_W:0]   sum_w;
    logic             carry;
    logic [7:0]       add_cnt_inc;

    assign in_ready    = (state_q == ST_ACCUM) && (acc_cnt_q < COUNT_C);
    assign out_valid   = (state_q == ST_DONE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    assign sum_w       = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mul_prod};
    assign carry       = sum_w[ACC_W];
    assign add_cnt_inc = add_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        acc_cnt_d  = acc_cnt_q;
        add_cnt_d  = add_cnt_q;
        s1_valid_d = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        if (accept) begin
            mul_a_d    = a;
            mul_b_d    = b;
            s1_valid_d = 1'b1;
            acc_cnt_d  = acc_cnt_q + 8'd1;
        end

        if (s1_valid_q) begin
`ifdef SATURATE_EN
            acc_d = carry ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
            acc_d = sum_w[ACC_W-1:0];
`endif
            ovf_d     = ovf_q | carry;
            add_cnt_d = add_cnt_inc;
            if (add_cnt_inc == COUNT_C) begin
                state_d = ST_DONE;
            end
        end

        // The last product was added on the edge that entered DONE, so the
        // add path is idle here and clearing cannot race an in-flight sum.
        if (release_out) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            acc_cnt_d = '0;
            add_cnt_d = '0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            acc_cnt_q  <= '0;
            add_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            add_cnt_q  <= add_cnt_d;
            s1_valid_q <= s1_valid_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mul_a    = mul_a_q;
    assign mul_b    = mul_b_q;
    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: three instances (COUNT = 8, 32, 1) with a
// behavioural multiplier; expected results are queued at stimulus time and popped on handshake.
module tb_mac_accumulator;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [1:0]  d;
        logic [11:0] acc;
        logic        ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [NDUT-1:0]  in_valid;
    logic [NDUT-1:0]  in_ready;
    logic [NDUT-1:0]  out_valid;
    logic [NDUT-1:0]  out_ready;
    logic [NDUT-1:0]  overflow;
    logic [3:0]       a        [NDUT];
    logic [3:0]       b        [NDUT];
    logic [3:0]       mul_a    [NDUT];
    logic [3:0]       mul_b    [NDUT];
    logic [7:0]       mul_prod [NDUT];
    logic [11:0]      acc_out  [NDUT];

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mac_accumulator #(
            .COUNT(g == 0 ? 8 : (g == 1 ? 32 : 1)),
            .ACC_W(12)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a[g]),
            .b        (b[g]),
            .mul_a    (mul_a[g]),
            .mul_b    (mul_b[g]),
            .mul_prod (mul_prod[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .acc_out  (acc_out[g]),
            .overflow (overflow[g])
        );
        assign mul_prod[g] = mul_a[g] * mul_b[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result monitor: a handshake is sampled at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_result_dut%0d", d), 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result_dut", d, int'(e.d));
                        chk($sformatf("acc_out_dut%0d", d), int'(acc_out[d]), int'(e.acc));
                        chk($sformatf("overflow_dut%0d", d), int'(overflow[d]), int'(e.ovf));
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [3:0] av, input logic [3:0] bv);
        bit ok;
        ok = 1'b0;
        in_valid[d] = 1'b1;
        a[d] = av;
        b[d] = bv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk($sformatf("accept_timeout_dut%0d", d), 0, 1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_scoreboard", int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int d);
        chk($sformatf("rst_in_ready_dut%0d", d), int'(in_ready[d]), 1);
        chk($sformatf("rst_mul_a_dut%0d", d), int'(mul_a[d]), 0);
        chk($sformatf("rst_mul_b_dut%0d", d), int'(mul_b[d]), 0);
        chk($sformatf("rst_acc_out_dut%0d", d), int'(acc_out[d]), 0);
        chk($sformatf("rst_out_valid_dut%0d", d), int'(out_valid[d]), 0);
        chk($sformatf("rst_overflow_dut%0d", d), int'(overflow[d]), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < NDUT; d++) begin
            a[d] = '0;
            b[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_reset(d);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic sum: 8 x 225 = 1800
        out_ready[0] = 1'b1;
        sb.push_back('{d: 2'd0, acc: 12'd1800, ovf: 1'b0});
        for (int k = 0; k < 8; k++) send(0, 4'd15, 4'd15);
        drain();

        // Bubbles and backpressure: sum of 2k for k=0..7 = 56
        out_ready[0] = 1'b0;
        sb.push_back('{d: 2'd0, acc: 12'd56, ovf: 1'b0});
        for (int k = 0; k < 8; k++) begin
            send(0, 4'(k), 4'd2);
            @(posedge clk);
            #1;
        end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bubble_out_valid_seen", int'(seen), 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_acc_out", int'(acc_out[0]), 56);
            chk("stall_in_ready", int'(in_ready[0]), 0);
            chk("stall_out_valid", int'(out_valid[0]), 1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_out_valid", int'(out_valid[0]), 0);
        chk("post_hs_acc_out", int'(acc_out[0]), 0);
        chk("post_hs_in_ready", int'(in_ready[0]), 1);

        // Reset mid-accumulation after three 9x9 pairs
        send(0, 4'd9, 4'd9);
        chk("restart_mul_a", int'(mul_a[0]), 9);
        send(0, 4'd9, 4'd9);
        send(0, 4'd9, 4'd9);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset(0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset(0);
        sb.push_back('{d: 2'd0, acc: 12'd8, ovf: 1'b0});
        for (int k = 0; k < 8; k++) send(0, 4'd1, 4'd1);
        drain();

        // Overflow: 32 x 225 = 7200
        out_ready[1] = 1'b1;
`ifdef SATURATE_EN
        sb.push_back('{d: 2'd1, acc: 12'd4095, ovf: 1'b1});
`else
        sb.push_back('{d: 2'd1, acc: 12'd3104, ovf: 1'b1});
`endif
        for (int k = 0; k < 32; k++) send(1, 4'd15, 4'd15);
        drain();

        // COUNT=1: result visible two cycles after the accept cycle begins
        out_ready[2] = 1'b1;
        sb.push_back('{d: 2'd2, acc: 12'd0, ovf: 1'b0});
        send(2, 4'd0, 4'd15);
        chk("cnt1_zero_valid_early", int'(out_valid[2]), 0);
        @(posedge clk);
        #1;
        chk("cnt1_zero_valid", int'(out_valid[2]), 1);
        sb.push_back('{d: 2'd2, acc: 12'd15, ovf: 1'b0});
        send(2, 4'd15, 4'd1);
        chk("cnt1_fifteen_valid_early", int'(out_valid[2]), 0);
        @(posedge clk);
        #1;
        chk("cnt1_fifteen_valid", int'(out_valid[2]), 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate stage that sits around the 4-bit combinational array multiplier.
- Registers incoming 4-bit operand pairs under a valid/ready handshake and drives them onto the multiplier inputs.
- Captures the 8-bit product one cycle later and sums COUNT products into an accumulator.
- Presents the finished sum downstream under a second valid/ready handshake.

## Interface
- COUNT, 8: products summed per result; legal range 1..255.
- ACC_W, 12: accumulator and result width; legal range 8..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair a/b is presented.
- in_ready  out  1  block accepts a/b this cycle.
- a  in  4  unsigned multiplicand.
- b  in  4  unsigned multiplier.
- mul_a  out  4  registered operand to multiplier a.
- mul_b  out  4  registered operand to multiplier b.
- mul_prod  in  8  multiplier product; combinational function of mul_a/mul_b.
- out_valid  out  1  acc_out holds a finished sum.
- out_ready  in  1  downstream takes the sum.
- acc_out  out  ACC_W  accumulated sum.
- overflow  out  1  sticky: the sum exceeded 2^ACC_W-1 during this result.

## Operation
- **States:**
  - ACCUM: accepting operands and summing.
  - DONE: holding the result.
  - Reset state is ACCUM.
- **Counters:** `acc_cnt` (8-bit) counts accepted pairs; `add_cnt` (8-bit) counts added products.
- **in_ready:** in_ready = (state==ACCUM) && (acc_cnt < COUNT). Combinational from registers only; never depends on in_valid.
- **Stage 1:** on in_valid && in_ready, register a→mul_a and b→mul_b, set s1_valid, and increment acc_cnt. Otherwise s1_valid clears, and mul_a/mul_b hold their values.
- **Stage 2:** when s1_valid, update acc ← acc + mul_prod in (ACC_W+1)-bit arithmetic and increment add_cnt. A carry out of bit ACC_W-1 sets overflow.
- **Wrap rule:** without saturation, acc keeps the low ACC_W bits, i.e. modulo 2^ACC_W.
- **ACCUM→DONE:** on the edge where add_cnt reaches COUNT, out_valid is set in the same edge.
- **DONE→ACCUM:** on out_valid && out_ready. The same edge clears acc, acc_cnt, add_cnt and overflow.
- **Result hold:** acc_out = acc at all times. It is stable while out_valid=1 and out_ready=0.
- **No simultaneous handshakes:** in_ready=0 throughout DONE, so input and output handshakes never occur in the same cycle. The first new pair can be accepted in the cycle after the output handshake.
- **Gaps in in_valid:** bubbles are legal; the block simply waits, with no timeout.
- **Reset:** rst_n low, including mid-accumulation, asynchronously clears all state. Partial sums are discarded.

## Timing
- **Reset values:**
  - in_ready=1
  - mul_a=0, mul_b=0
  - acc_out=0
  - out_valid=0
  - overflow=0
- **Throughput:** one operand pair per cycle while in_ready=1.
- **Latency:** a pair accepted at edge k is added at edge k+1. If it is the COUNT-th pair, out_valid=1 is visible after edge k+1, i.e. two cycles after the accept cycle begins.
- **Minimum result period:** COUNT+2 cycles with in_valid held high and out_ready held high, covering the accept cycles, the add edge and the handshake cycle.
- **Multiplier path:** mul_prod must settle within one clk period of mul_a/mul_b changing. No multicycle path is allowed.
- **Output stability:** out_valid, once asserted, stays high until the handshake. acc_out and overflow are frozen while out_valid=1.

## Configuration
- **SATURATE_EN defined:** on a carry out, acc clamps to 2^ACC_W-1 and stays there for the rest of the result. overflow is still set.
- **SATURATE_EN undefined:** acc wraps modulo 2^ACC_W; overflow is set on the first carry.

## Test plan
- **Basic sum:** COUNT=8, eight back-to-back pairs a=15, b=15, out_ready=1. Requires out_valid pulse with acc_out=1800 (0x708) and overflow=0.
- **Bubbles and backpressure:** COUNT=8, pairs a=k, b=2 for k=0..7 with in_valid low every other cycle, out_ready=0 for 5 cycles after out_valid.
  - acc_out=56 held constant and in_ready=0 during the stall.
  - Next accept occurs one cycle after the handshake, with acc restarted at 0.
- **Overflow without SATURATE_EN:** COUNT=32, ACC_W=12, 32 pairs of 15×15. Requires acc_out=3104 (7200 mod 4096) and overflow=1.
- **Overflow with SATURATE_EN:** same stimulus as the previous scenario. Requires acc_out=4095 and overflow=1.
- **Reset mid-accumulation:** COUNT=8, three pairs 9×9, then rst_n low for 2 cycles.
  - All outputs at their reset values.
  - Then eight pairs 1×1 give acc_out=8 and overflow=0.
- **Zero operands and COUNT=1:**
  - a=0, b=15 gives acc_out=0.
  - a=15, b=1 gives acc_out=15.
  - Each result has out_valid high two cycles after its accept cycle.
